// File: rtl/conv_output_writer_pkg.sv
// Shared layer definitions for the convolution output writer: FSM encoding,
// default geometry, derived output dimensions and the counter-width helper.
package conv_output_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } wr_state_e;

    localparam int IN_COLS_DEF    = 100;
    localparam int IN_ROWS_DEF    = 100;
    localparam int KERNEL_DEF     = 3;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int ADDR_WIDTH_DEF = 14;

    localparam int OUT_COLS = IN_COLS_DEF - KERNEL_DEF + 1;
    localparam int OUT_ROWS = IN_ROWS_DEF - KERNEL_DEF + 1;

    function automatic int out_dim(input int in_dim, input int kernel);
        return in_dim - kernel + 1;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_window_position.sv
// Input column/row tracker for the convolution writer. Flags positions whose
// kernel window lies fully inside the frame and the final pixel of the frame.
module conv_window_position
    import conv_output_writer_pkg::*;
#(
    parameter int IN_COLS = IN_COLS_DEF,
    parameter int IN_ROWS = IN_ROWS_DEF,
    parameter int KERNEL  = KERNEL_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_advance,
    output logic o_pos_valid,
    output logic o_last_pos
);

    localparam int COL_W = cnt_width(IN_COLS);
    localparam int ROW_W = cnt_width(IN_ROWS);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             w_col_wrap;
    logic             w_row_wrap;

    assign w_col_wrap = (r_col == COL_W'(IN_COLS - 1));
    assign w_row_wrap = (r_row == ROW_W'(IN_ROWS - 1));

    // Raster-order position counters; the row wraps too so a finished frame rests at origin.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_col <= {COL_W{1'b0}};
            r_row <= {ROW_W{1'b0}};
        end else if (i_advance) begin
            if (w_col_wrap) begin
                r_col <= {COL_W{1'b0}};
                r_row <= w_row_wrap ? {ROW_W{1'b0}} : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    assign o_pos_valid = (r_col >= COL_W'(KERNEL - 1)) && (r_row >= ROW_W'(KERNEL - 1));
    assign o_last_pos  = w_col_wrap && w_row_wrap;

endmodule

// File: rtl/conv_output_writer.sv
// Writes valid convolution results to the output feature map at dense addresses.
// Optional fused ReLU on the write data when CONV_WRITER_RELU_EN is defined.
module conv_output_writer
    import conv_output_writer_pkg::*;
#(
    parameter int IN_COLS    = IN_COLS_DEF,
    parameter int IN_ROWS    = IN_ROWS_DEF,
    parameter int KERNEL     = KERNEL_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic                         i_in_valid,
    input  logic signed [DATA_WIDTH-1:0] i_in_data,
    output logic                         o_wr_en,
    output logic        [ADDR_WIDTH-1:0] o_wr_addr,
    output logic        [DATA_WIDTH-1:0] o_wr_data,
    output logic                         o_busy,
    output logic                         o_done
);

    localparam int L_OUT_COLS = out_dim(IN_COLS, KERNEL);
    localparam int L_OUT_ROWS = out_dim(IN_ROWS, KERNEL);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(L_OUT_COLS * L_OUT_ROWS - 1);

    wr_state_e                    r_state;
    wr_state_e                    w_state_nxt;
    logic                         w_start_acc;
    logic                         w_accept;
    logic                         w_keep;
    logic                         w_pos_valid;
    logic                         w_last_pos;
    logic                         r_tail;
    logic        [ADDR_WIDTH-1:0] r_addr_cnt;
    logic                         r_wr_en;
    logic        [ADDR_WIDTH-1:0] r_wr_addr;
    logic        [DATA_WIDTH-1:0] r_wr_data;
    logic signed [DATA_WIDTH-1:0] w_wr_data;
    logic                         w_busy;
    logic                         w_done;

    // r_tail blocks further inputs once the final pixel has been taken.
    assign w_start_acc = (r_state == ST_IDLE) && i_start;
    assign w_accept    = (r_state == ST_RUN) && i_in_valid && !r_tail;
    assign w_keep      = w_accept && w_pos_valid;

`ifdef CONV_WRITER_RELU_EN
    assign w_wr_data = i_in_data[DATA_WIDTH-1] ? {DATA_WIDTH{1'b0}} : i_in_data;
`else
    assign w_wr_data = i_in_data;
`endif

    conv_window_position #(
        .IN_COLS (IN_COLS),
        .IN_ROWS (IN_ROWS),
        .KERNEL  (KERNEL)
    ) u_pos (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clear     (w_start_acc),
        .i_advance   (w_accept),
        .o_pos_valid (w_pos_valid),
        .o_last_pos  (w_last_pos)
    );

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: leave RUN while the final write is on the bus, so Done trails it by one cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (r_wr_en && (r_wr_addr == LAST_ADDR)) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            ST_RUN:  w_busy = 1'b1;
            ST_DONE: w_done = 1'b1;
            default: begin
                w_busy = 1'b0;
                w_done = 1'b0;
            end
        endcase
    end

    // Address counter and registered write port.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr_cnt <= {ADDR_WIDTH{1'b0}};
            r_tail     <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= {ADDR_WIDTH{1'b0}};
            r_wr_data  <= {DATA_WIDTH{1'b0}};
        end else begin
            r_wr_en <= w_keep;
            if (w_start_acc) begin
                r_addr_cnt <= {ADDR_WIDTH{1'b0}};
                r_tail     <= 1'b0;
            end else begin
                if (w_keep) begin
                    r_addr_cnt <= r_addr_cnt + ADDR_WIDTH'(1);
                end
                if (w_accept && w_last_pos) begin
                    r_tail <= 1'b1;
                end
            end
            if (w_keep) begin
                r_wr_addr <= r_addr_cnt;
                r_wr_data <= w_wr_data;
            end
        end
    end

    assign o_wr_en   = r_wr_en;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_data = r_wr_data;
    assign o_busy    = w_busy;
    assign o_done    = w_done;

endmodule

// File: tb/tb_conv_output_writer.sv
// Self-checking bench for conv_output_writer: frame-level reference model,
// spot-value table, and hand sequences for Start/Rst/idle corner cases.
module tb_conv_output_writer;

    localparam int IN_COLS  = 100;
    localparam int IN_ROWS  = 100;
    localparam int KERNEL   = 3;
    localparam int DW       = 16;
    localparam int AW       = 14;
    localparam int OUT_COLS = IN_COLS - KERNEL + 1;
    localparam int OUT_ROWS = IN_ROWS - KERNEL + 1;
    localparam int N_IN     = IN_COLS * IN_ROWS;
    localparam int N_OUT    = OUT_COLS * OUT_ROWS;
`ifdef CONV_WRITER_RELU_EN
    localparam int EXP_NEG5 = 0;
`else
    localparam int EXP_NEG5 = 'hFFFB;
`endif

    typedef struct { int addr; int data; int cyc; } wr_t;
    typedef struct { string name; int addr; int data; } spot_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;

    int  tests = 0;
    int  fails = 0;
    int  cyc   = 0;
    bit  mon_on = 1'b0;
    wr_t exp_q[$];
    wr_t got_q[$];
    int  done_q[$];

    conv_output_writer #(
        .IN_COLS(IN_COLS), .IN_ROWS(IN_ROWS), .KERNEL(KERNEL),
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_in_valid(in_valid),
        .i_in_data(in_data), .o_wr_en(wr_en), .o_wr_addr(wr_addr),
        .o_wr_data(wr_data), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_on && wr_en) got_q.push_back('{int'(wr_addr), int'(wr_data), cyc});
        if (mon_on && done) done_q.push_back(cyc);
    end

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_out(input logic [DW-1:0] d);
`ifdef CONV_WRITER_RELU_EN
        if ($signed(d) < 0) return 0;
`endif
        return int'(d);
    endfunction

    function automatic logic [DW-1:0] pix_data(input int p, input bit neg);
        logic [DW-1:0] v;
        v = DW'(p);
        if (neg && p == 202)  v = 16'hFFFB;
        if (neg && p == 5555) v = 16'h8000;
        return v;
    endfunction

    // Drives one frame of n inputs (optional random gaps, optional mid-frame Start).
    task automatic run_frame(input int gap_pct, input int mid_start_at, input int n, input bit neg);
        int p;
        int r;
        int c;
        p = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (p < n) begin
            start = (p == mid_start_at);
            if (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = DW'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = pix_data(p, neg);
                r = p / IN_COLS;
                c = p % IN_COLS;
                if (r >= KERNEL - 1 && c >= KERNEL - 1)
                    exp_q.push_back('{(r - (KERNEL - 1)) * OUT_COLS + (c - (KERNEL - 1)),
                                      ref_out(in_data), cyc + 1});
                p++;
            end
            @(posedge clk); #1;
        end
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input bit start_on_done);
        bit seen;
        int busy_hi;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, seen, 1);
        if (seen) check({tag, "_busy_low_on_done"}, busy, 0);
        if (start_on_done) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_hi = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (busy) busy_hi++;
        end
        check({tag, "_busy_after_frame"}, busy_hi, 0);
    endtask

    task automatic compare_frame(input string tag);
        int bad;
        int first;
        bad   = 0;
        first = -1;
        check({tag, "_wr_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (got_q[i].addr != exp_q[i].addr || got_q[i].data != exp_q[i].data ||
                got_q[i].cyc != exp_q[i].cyc) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        check({tag, "_pairs_wrong"}, bad, 0);
        if (first >= 0)
            $display("  %s write #%0d: addr %0d data %0d cyc %0d; model addr %0d data %0d cyc %0d",
                     tag, first, got_q[first].addr, got_q[first].data, got_q[first].cyc,
                     exp_q[first].addr, exp_q[first].data, exp_q[first].cyc);
    endtask

    function automatic int find_data(input int addr);
        foreach (got_q[i]) if (got_q[i].addr == addr) return got_q[i].data;
        return -1;
    endfunction

    initial begin
        spot_t spots[6];
        int    rcyc;
        int    late;
        spots[0] = '{"first_addr0",  0,    202};
        spots[1] = '{"addr1",        1,    203};
        spots[2] = '{"row_end97",    97,   299};
        spots[3] = '{"row_start98",  98,   302};
        spots[4] = '{"mid_4851",     4851, 5151};
        spots[5] = '{"last_9603",    9603, 9999};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_wr_en", wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);

        // Inputs while idle must be ignored and must not move the counters.
        mon_on = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = DW'(1000 + i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("idle_no_writes", got_q.size(), 0);
        check("idle_busy", busy, 0);

        // Frame A: back-to-back index stream.
        exp_q.delete(); got_q.delete(); done_q.delete();
        run_frame(0, -1, N_IN, 1'b0);
        wait_done("A", 1'b0);
        check("A_model_count", exp_q.size(), N_OUT);
        compare_frame("A");
        for (int i = 0; i < 6; i++) check({"A_", spots[i].name}, find_data(spots[i].addr), spots[i].data);
        check("A_done_pulses", done_q.size(), 1);
        if (done_q.size() > 0 && got_q.size() > 0)
            check("A_done_latency", done_q[0] - got_q[got_q.size() - 1].cyc, 1);

        // Frame B: random gaps, negative data, Start mid-frame and on Done.
        exp_q.delete(); got_q.delete(); done_q.delete();
        run_frame(30, 3000, N_IN, 1'b1);
        wait_done("B", 1'b1);
        compare_frame("B");
        check("B_neg5_at_2_2", find_data(0), EXP_NEG5);
        check("B_row_end97", find_data(97), 299);
        check("B_done_pulses", done_q.size(), 1);
        if (done_q.size() > 0 && got_q.size() > 0)
            check("B_done_latency", done_q[0] - got_q[got_q.size() - 1].cyc, 1);

        // Reset after 5000 inputs aborts without Done.
        exp_q.delete(); got_q.delete(); done_q.delete();
        run_frame(0, -1, 5000, 1'b0);
        rst = 1'b1; in_valid = 1'b1; in_data = DW'(5000);
        rcyc = cyc;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("R_busy_after_rst", busy, 0);
        check("R_wr_en_after_rst", wr_en, 0);
        repeat (30) @(negedge clk);
        check("R_no_done", done_q.size(), 0);
        late = 0;
        foreach (got_q[i]) if (got_q[i].cyc > rcyc) late++;
        check("R_writes_after_rst", late, 0);
        compare_frame("R_partial");

        // Frame C: fresh frame after abort restarts at address 0.
        exp_q.delete(); got_q.delete(); done_q.delete();
        run_frame(0, -1, N_IN, 1'b0);
        wait_done("C", 1'b0);
        compare_frame("C");
        check("C_first_addr", (got_q.size() > 0) ? got_q[0].addr : -1, 0);
        check("C_first_data", (got_q.size() > 0) ? got_q[0].data : -1, 202);
        check("C_done_pulses", done_q.size(), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/conv_output_writer.md
# conv_output_writer

Consumer-side companion to the convolution column/row window tracking in the Layer 5 datapath. Accepts one convolution result per input-pixel position from the MAC pipeline and tracks the input column and row itself. It discards results whose kernel window overhangs the left or top edge, and writes the valid results to the output feature-map memory at sequential addresses. It signals frame completion to the layer controller.

## Interface
- `IN_COLS`, 100, input feature-map width in pixels
- `IN_ROWS`, 100, input feature-map height in pixels
- `KERNEL`, 3, square kernel size; output is (IN_COLS-KERNEL+1) x (IN_ROWS-KERNEL+1)
- `DATA_WIDTH`, 16, signed result width
- `ADDR_WIDTH`, 14, output memory address width; must hold OUT_COLS*OUT_ROWS-1
- `Clk`  in  1  clock, all logic on rising edge
- `Rst`  in  1  synchronous, active-high reset
- `Start`  in  1  single-cycle pulse; begins a frame when idle
- `In_Valid`  in  1  `In_Data` holds the result for the next input-pixel position
- `In_Data`  in  DATA_WIDTH  signed convolution result
- `Wr_En`  out  1  memory write strobe
- `Wr_Addr`  out  ADDR_WIDTH  output memory address
- `Wr_Data`  out  DATA_WIDTH  output memory data
- `Busy`  out  1  high from accepted `Start` until `Done`
- `Done`  out  1  single-cycle pulse after the last write of a frame

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on `Start`. This clears the column counter, row counter and address counter.
  - RUN -> DONE on the cycle that issues the write to address OUT_COLS*OUT_ROWS-1.
  - DONE -> IDLE unconditionally after one cycle.
- In RUN, each `In_Valid` cycle advances the column counter, 0..IN_COLS-1.
  - At column IN_COLS-1 the column counter wraps to 0 and the row counter increments.
- A result is kept only when column >= KERNEL-1 and row >= KERNEL-1, with the counters evaluated before the increment. Otherwise it is dropped silently.
- Each kept result produces one write at the current address counter value, then the address counter increments by 1.
- Addresses are row-major and dense: 0..OUT_COLS*OUT_ROWS-1. There are no gaps at row boundaries.
- `In_Valid` is ignored in IDLE and DONE. `In_Valid` low in RUN holds all counters.
- `Start` is ignored while `Busy` is high.
- No backpressure: the memory accepts one write per cycle.
- `In_Data` is treated as signed two's complement and is never widened or truncated.

## Timing
- Reset values:
  - state IDLE
  - all counters 0
  - `Wr_En`, `Busy` and `Done` all 0
  - `Wr_Addr` 0 and `Wr_Data` 0
- `Rst` in any state aborts the frame on the next edge. No partial `Done` is produced.
- `Wr_En`, `Wr_Addr` and `Wr_Data` are registered with 1-cycle latency from the accepting `In_Valid` edge.
- `Busy` rises the cycle after `Start` and falls in the same cycle that `Done` is high.
- `Done` goes high the cycle after the final `Wr_En` and lasts exactly 1 cycle.
- A `Start` in the cycle `Done` is high is ignored. A `Start` in the following IDLE cycle is accepted.
- Throughput is one input per cycle, sustained, with no bubbles at row wrap.
- Frame length is IN_COLS*IN_ROWS accepted inputs, with exactly OUT_COLS*OUT_ROWS writes.

## Configuration
- `CONV_WRITER_RELU_EN` defined: `Wr_Data` = 0 when `In_Data` is negative, otherwise `In_Data`. This is the fused ReLU.
- `CONV_WRITER_RELU_EN` not defined: `Wr_Data` = `In_Data` unchanged.
- Timing, addressing and the count of writes are identical in both builds.

## Structure
- The shared layer package holds:
  - the FSM state encoding (IDLE/RUN/DONE)
  - derived constants OUT_COLS = IN_COLS-KERNEL+1 and OUT_ROWS = IN_ROWS-KERNEL+1
  - the counter width function (clog2)
- One sub-module, `conv_window_position`, is natural. It holds the column/row counters with wrap and emits `Pos_Valid` (column and row both >= KERNEL-1) and `Last_Pos`.
- The FSM, address counter, ReLU and output registers stay in `conv_output_writer`.

## Test plan
- Reset then `Start`, followed by 10000 back-to-back `In_Valid` with `In_Data` equal to the pixel index. Required response:
  - exactly 9604 writes
  - the first write has addr 0 with data 202 (row 2, column 2)
  - addr 97 has data 299
  - addr 98 has data 302
  - the last write has addr 9603 with data 9999
  - `Done` is high 1 cycle after the last write
- The same stream with random `In_Valid` gaps produces identical addr/data pairs, each 1 cycle after its accepting input. The counters hold during gaps.
- `In_Data` = -5 at position (2,2): `Wr_Data` = 0 with `CONV_WRITER_RELU_EN` defined, and 0xFFFB without it.
- `Start` pulsed mid-frame and again on the `Done` cycle: both are ignored. The frame completes normally and `Busy` stays 0 afterwards.
- `Rst` asserted after 5000 inputs: the next cycle shows `Busy`=0 and `Wr_En`=0, with no `Done` pulse. A fresh frame starts again from address 0.
- `In_Valid` pulses in IDLE before `Start`: no writes occur and the counters stay 0.
